// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and constants for the data-memory responder
package dmem_pkg;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam int CNT_W      = 4;
    localparam int WORD_BYTES = 4;
    localparam int WORD_SHIFT = $clog2(WORD_BYTES);
endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - word storage with one synchronous write and one synchronous read port
module dmem_array #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 512,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic              i_re,
    input  logic [IDX_W-1:0]  i_idx,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    // Contents are deliberately not reset; read data holds until the next read.
    always_ff @(posedge i_clk) begin
        if (i_we) r_mem[i_idx] <= i_wdata;
        if (i_re) r_rdata <= r_mem[i_idx];
    end

    assign o_rdata = r_rdata;
endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - wait-state data-memory responder with valid/ready request and response channels
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int DEPTH   = 512,
    parameter int LATENCY = 2
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_we,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic [DATA_W-1:0] i_req_wdata,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [DATA_W-1:0] o_rsp_rdata,
    output logic              o_rsp_err
);
    localparam int IDX_W = $clog2(DEPTH);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_req_ready;
    logic              r_rsp_valid;
    logic              r_rsp_err;
    logic              r_rsp_load;
    logic              w_accept;
    logic              w_access;
    logic              w_err;
    logic [DATA_W-1:0] w_arr_rdata;

    assign w_err = (r_addr[WORD_SHIFT-1:0] != '0) ||
                   ((r_addr >> WORD_SHIFT) >= ADDR_W'(DEPTH));

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_access    = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_req_valid && r_req_ready) begin
                    w_accept    = 1'b1;
                    w_state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (r_cnt == '0) begin
                    w_access    = 1'b1;
                    w_state_nxt = RESP;
                end
            end
            RESP: begin
                if (i_rsp_ready) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_req_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_load  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            // Ready/valid follow the next state so both flip on the transition edge.
            r_req_ready <= (w_state_nxt == IDLE);
            r_rsp_valid <= (w_state_nxt == RESP);
            if (w_accept) begin
                r_we    <= i_req_we;
                r_addr  <= i_req_addr;
                r_wdata <= i_req_wdata;
                r_cnt   <= CNT_W'(LATENCY - 1);
            end else if (r_state == WAIT && r_cnt != '0) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
            if (w_access) begin
                r_rsp_err  <= w_err;
                r_rsp_load <= !w_err && !r_we;
            end
        end
    end

    dmem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .i_clk   (i_clk),
        .i_we    (w_access && r_we && !w_err),
        .i_re    (w_access && !r_we && !w_err),
        .i_idx   (r_addr[WORD_SHIFT +: IDX_W]),
        .i_wdata (r_wdata),
        .o_rdata (w_arr_rdata)
    );

    assign o_req_ready = r_req_ready;
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_err   = r_rsp_err;
    assign o_rsp_rdata = r_rsp_load ? w_arr_rdata : '0;
endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed bench for dmem_responder at latencies 2, 4 and 1
module tb_dmem_responder;
    logic        clk = 1'b0;
    logic        rst_n     [3];
    logic        req_valid [3];
    logic        req_ready [3];
    logic        req_we    [3];
    logic [31:0] req_addr  [3];
    logic [31:0] req_wdata [3];
    logic        rsp_valid [3];
    logic        rsp_ready [3];
    logic [31:0] rsp_rdata [3];
    logic        rsp_err   [3];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_responder #(.LATENCY(2)) u_dut_l2 (
        .i_clk(clk), .i_rst_n(rst_n[0]), .i_req_valid(req_valid[0]), .o_req_ready(req_ready[0]),
        .i_req_we(req_we[0]), .i_req_addr(req_addr[0]), .i_req_wdata(req_wdata[0]),
        .o_rsp_valid(rsp_valid[0]), .i_rsp_ready(rsp_ready[0]), .o_rsp_rdata(rsp_rdata[0]),
        .o_rsp_err(rsp_err[0]));

    dmem_responder #(.LATENCY(4)) u_dut_l4 (
        .i_clk(clk), .i_rst_n(rst_n[1]), .i_req_valid(req_valid[1]), .o_req_ready(req_ready[1]),
        .i_req_we(req_we[1]), .i_req_addr(req_addr[1]), .i_req_wdata(req_wdata[1]),
        .o_rsp_valid(rsp_valid[1]), .i_rsp_ready(rsp_ready[1]), .o_rsp_rdata(rsp_rdata[1]),
        .o_rsp_err(rsp_err[1]));

    dmem_responder #(.LATENCY(1)) u_dut_l1 (
        .i_clk(clk), .i_rst_n(rst_n[2]), .i_req_valid(req_valid[2]), .o_req_ready(req_ready[2]),
        .i_req_we(req_we[2]), .i_req_addr(req_addr[2]), .i_req_wdata(req_wdata[2]),
        .o_rsp_valid(rsp_valid[2]), .i_rsp_ready(rsp_ready[2]), .o_rsp_rdata(rsp_rdata[2]),
        .o_rsp_err(rsp_err[2]));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One complete transaction; hold > 0 keeps rsp_ready low for that many cycles after rsp_valid.
    task automatic xact(input int d, input string tag, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input int exp_lat, input logic [31:0] exp_rdata,
                        input logic exp_err, input int hold);
        int n;
        int lat;
        req_valid[d] = 1'b1;
        req_we[d]    = we;
        req_addr[d]  = addr;
        req_wdata[d] = wdata;
        rsp_ready[d] = (hold == 0);
        n = 0;
        while (!req_ready[d] && n < 20) begin tick(); n++; end
        chk({tag, ".ready"}, req_ready[d], 1'b1);
        tick();
        req_valid[d] = 1'b0;
        req_addr[d]  = ~addr;
        req_wdata[d] = ~wdata;
        req_we[d]    = ~we;
        chk({tag, ".busy"}, req_ready[d], 1'b0);
        lat = 0;
        while (!rsp_valid[d] && lat < 40) begin tick(); lat++; end
        chk({tag, ".latency"}, lat, exp_lat);
        chk({tag, ".rdata"}, rsp_rdata[d], exp_rdata);
        chk({tag, ".err"}, rsp_err[d], exp_err);
        for (int i = 0; i < hold; i++) begin
            tick();
            chk({tag, ".hold_valid"}, rsp_valid[d], 1'b1);
            chk({tag, ".hold_rdata"}, rsp_rdata[d], exp_rdata);
            chk({tag, ".hold_ready"}, req_ready[d], 1'b0);
        end
        rsp_ready[d] = 1'b1;
        tick();
        chk({tag, ".done_valid"}, rsp_valid[d], 1'b0);
        chk({tag, ".done_ready"}, req_ready[d], 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        int acc;
        int prev;
        for (int d = 0; d < 3; d++) begin
            rst_n[d] = 1'b0; req_valid[d] = 1'b0; req_we[d] = 1'b0;
            req_addr[d] = '0; req_wdata[d] = '0; rsp_ready[d] = 1'b1;
        end
        repeat (3) tick();
        chk("rst.req_ready", req_ready[0], 1'b0);
        chk("rst.rsp_valid", rsp_valid[0], 1'b0);
        chk("rst.rsp_rdata", rsp_rdata[0], 32'h0);
        chk("rst.rsp_err", rsp_err[0], 1'b0);
        for (int d = 0; d < 3; d++) rst_n[d] = 1'b1;
        chk("rel.before_edge", req_ready[0], 1'b0);
        tick();
        chk("rel.after_edge", req_ready[0], 1'b1);

        // Latency 2: stores, loads, errors, top-of-array boundary, back-pressure.
        xact(0, "st0", 1'b1, 32'h0000_0000, 32'h5A5A_0001, 2, 32'h0, 1'b0, 0);
        xact(0, "st10", 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 2, 32'h0, 1'b0, 0);
        xact(0, "ld10", 1'b0, 32'h0000_0010, 32'h0, 2, 32'hDEAD_BEEF, 1'b0, 0);
        xact(0, "ld13", 1'b0, 32'h0000_0013, 32'h0, 2, 32'h0, 1'b1, 0);
        xact(0, "st800", 1'b1, 32'h0000_0800, 32'h0000_FFFF, 2, 32'h0, 1'b1, 0);
        xact(0, "ld0", 1'b0, 32'h0000_0000, 32'h0, 2, 32'h5A5A_0001, 1'b0, 0);
        xact(0, "st7fc", 1'b1, 32'h0000_07FC, 32'h0000_0077, 2, 32'h0, 1'b0, 0);
        xact(0, "ld7fc", 1'b0, 32'h0000_07FC, 32'h0, 2, 32'h0000_0077, 1'b0, 0);
        xact(0, "bp", 1'b0, 32'h0000_0010, 32'h0, 2, 32'hDEAD_BEEF, 1'b0, 5);

        // Latency 4: reset one cycle after accepting a store must drop it.
        xact(1, "l4st", 1'b1, 32'h0000_0020, 32'hCAFE_0020, 4, 32'h0, 1'b0, 0);
        req_valid[1] = 1'b1; req_we[1] = 1'b1;
        req_addr[1] = 32'h0000_0020; req_wdata[1] = 32'h0000_1234;
        tick();
        req_valid[1] = 1'b0;
        chk("mid.accepted", req_ready[1], 1'b0);
        tick();
        rst_n[1] = 1'b0;
        tick();
        chk("mid.rst_valid", rsp_valid[1], 1'b0);
        chk("mid.rst_ready", req_ready[1], 1'b0);
        rst_n[1] = 1'b1;
        seen = 0;
        repeat (6) begin tick(); if (rsp_valid[1]) seen++; end
        chk("mid.no_rsp", seen, 0);
        xact(1, "l4ld", 1'b0, 32'h0000_0020, 32'h0, 4, 32'hCAFE_0020, 1'b0, 0);

        // Latency 1: fill eight words, then stream loads with req_valid held high.
        for (int i = 0; i < 8; i++)
            xact(2, "l1st", 1'b1, 32'(i * 4), 32'h100 + 32'(i), 1, 32'h0, 1'b0, 0);
        req_valid[2] = 1'b1; req_we[2] = 1'b0; rsp_ready[2] = 1'b1;
        prev = 0;
        for (int i = 0; i < 8; i++) begin
            int n;
            req_addr[2] = 32'(i * 4);
            n = 0;
            while (!req_ready[2] && n < 10) begin tick(); n++; end
            tick();
            acc = cyc;
            if (i > 0) chk("b2b.spacing", acc - prev, 3);
            prev = acc;
            tick();
            chk("b2b.valid", rsp_valid[2], 1'b1);
            chk("b2b.rdata", rsp_rdata[2], 32'h100 + 32'(i));
            tick();
        end
        req_valid[2] = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
